// File: rtl/mano_io_term_if.sv
// ----------------------------------------------------------------------------
// mano_io_term_if
// Groups the terminal responder's datapath-side and serial-pin signals.
//
// Parameters:
//   CHARWIDTH : INPR/OUTR width and serial data bits per frame
//
// Signals:
//   rxd        serial input, idle high, asynchronous to the system clock
//   txd        serial output, idle high
//   FGI        current input-flag level from the datapath
//   FGO        current output-flag level from the datapath
//   OUTR       output register contents
//   out_start  one-cycle pulse: OUT instruction executed
//   err_clr    clears the sticky error flags
//   inpr_data  received character, drives the INPR load input
//   inpr_ld    one-cycle pulse: load INPR from inpr_data
//   fgi_set    one-cycle pulse: set FGI
//   fgo_set    one-cycle pulse: set FGO
//   tx_busy    high while a frame is being transmitted
//   rx_ovr     sticky: character dropped because FGI was still set
//   rx_ferr    sticky: framing (or parity) error
//
// Modports:
//   slave  : the terminal responder (mano_io_term)
//   master : the datapath / serial environment driving it
// ----------------------------------------------------------------------------
interface mano_io_term_if #(
  parameter int CHARWIDTH = 8
);
  logic                 rxd;
  logic                 txd;
  logic                 FGI;
  logic                 FGO;
  logic [CHARWIDTH-1:0] OUTR;
  logic                 out_start;
  logic                 err_clr;
  logic [CHARWIDTH-1:0] inpr_data;
  logic                 inpr_ld;
  logic                 fgi_set;
  logic                 fgo_set;
  logic                 tx_busy;
  logic                 rx_ovr;
  logic                 rx_ferr;

  modport slave (
    input  rxd, FGI, FGO, OUTR, out_start, err_clr,
    output txd, inpr_data, inpr_ld, fgi_set, fgo_set, tx_busy, rx_ovr, rx_ferr
  );

  modport master (
    output rxd, FGI, FGO, OUTR, out_start, err_clr,
    input  txd, inpr_data, inpr_ld, fgi_set, fgo_set, tx_busy, rx_ovr, rx_ferr
  );
endinterface

// File: rtl/mano_io_term.sv
// ----------------------------------------------------------------------------
// mano_io_term
// Terminal-side I/O responder for the MANO computer: the device end of the
// FGI/FGO handshake. Received 8N1 characters are handed to INPR with an
// FGI set pulse; an OUT instruction starts serialisation of OUTR on txd and
// FGO is set again once the frame (including the stop bit) has gone out.
//
// Parameters:
//   CLKS_PER_BIT : mclk cycles per serial bit (even, >= 4)
//   CHARWIDTH    : data bits per frame, INPR/OUTR width
//
// Ports:
//   mclk  : system clock
//   mrst  : synchronous active-high reset
//   io    : mano_io_term_if.slave (flags, registers, serial pins, status)
//
// Build option:
//   MANO_IO_PARITY_EN : when defined, an even-parity bit follows the data
//                       bits in both directions (CHARWIDTH+3 bit frames);
//                       an rx parity mismatch drops the character and sets
//                       rx_ferr.
// ----------------------------------------------------------------------------
module mano_io_term #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CHARWIDTH    = 8
) (
  input  logic              mclk,
  input  logic              mrst,
  mano_io_term_if.slave     io
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (CHARWIDTH > 2) ? $clog2(CHARWIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHARWIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [CHARWIDTH-1:0] CHAR_ZERO = {CHARWIDTH{1'b0}};

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_LOAD  = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_PAR   = 3'd4,
    TX_STOP  = 3'd5,
    TX_DONE  = 3'd6
  } tx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_par(input logic [CHARWIDTH-1:0] d);
    return ^d;
  endfunction

  // FGO is only observed by the datapath; this block never needs its level.
  logic unused_fgo_s;
  assign unused_fgo_s = io.FGO;

  // ---------------- receive side state ----------------
  logic                 rxd_s1_q, rxd_s1_d;
  logic                 rxd_s2_q, rxd_s2_d;
  logic                 rxd_prev_q, rxd_prev_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [CHARWIDTH-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_err_q, rx_par_err_d;
  logic [CHARWIDTH-1:0] inpr_data_q, inpr_data_d;
  logic                 inpr_ld_q, inpr_ld_d;
  logic                 fgi_set_q, fgi_set_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_tick_s;

  // ---------------- transmit side state ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [CHARWIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 txd_q, txd_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 fgo_set_q, fgo_set_d;
  logic                 tx_tick_s;

  // Receive synchroniser, rx FSM next-state and sticky error flag logic.
  always_comb begin
    rxd_s1_d     = io.rxd;
    rxd_s2_d     = rxd_s1_q;
    rxd_prev_d   = rxd_s2_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    rx_par_err_d = rx_par_err_q;
    inpr_data_d  = inpr_data_q;
    inpr_ld_d    = 1'b0;
    fgi_set_d    = 1'b0;
    rx_tick_s    = (rx_cnt_q == CNT_ZERO);

    // Clear first so that an error event below in the same cycle wins.
    if (io.err_clr) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
    end else begin
      rx_ovr_d  = rx_ovr_q;
      rx_ferr_d = rx_ferr_q;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_HALF;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end

      RX_START: begin
        if (rx_tick_s) begin
          // Still low at mid-bit: a real start bit; otherwise a glitch.
          if (!rxd_s2_q) begin
            rx_state_d   = RX_DATA;
            rx_cnt_d     = CNT_FULL;
            rx_bit_d     = BIT_ZERO;
            rx_par_err_d = 1'b0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end

      RX_DATA: begin
        if (rx_tick_s) begin
          // LSB arrives first, so shift in from the top.
          rx_sh_d  = {rxd_s2_q, rx_sh_q[CHARWIDTH-1:1]};
          rx_cnt_d = CNT_FULL;
          if (rx_bit_q == BIT_LAST) begin
`ifdef MANO_IO_PARITY_EN
            rx_state_d = RX_PAR;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end

      RX_PAR: begin
        if (rx_tick_s) begin
          rx_par_err_d = (rxd_s2_q != even_par(rx_sh_q));
          rx_state_d   = RX_STOP;
          rx_cnt_d     = CNT_FULL;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end

      RX_STOP: begin
        if (rx_tick_s) begin
          rx_state_d = RX_IDLE;
          if (rxd_s2_q && !rx_par_err_q) begin
            if (!io.FGI) begin
              inpr_data_d = rx_sh_q;
              inpr_ld_d   = 1'b1;
              fgi_set_d   = 1'b1;
            end else begin
              rx_ovr_d = 1'b1;
            end
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end

      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
        rx_bit_d   = BIT_ZERO;
      end
    endcase
  end

  // Transmit FSM next-state, serial output and FGO handshake logic.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    fgo_set_d  = 1'b0;
    tx_tick_s  = (tx_cnt_q == CNT_ZERO);

    case (tx_state_q)
      TX_IDLE: begin
        if (io.out_start) begin
          tx_state_d = TX_LOAD;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end

      // OUTR was written on the out_start edge, so it is valid only now.
      TX_LOAD: begin
        tx_sh_d    = io.OUTR;
        tx_par_d   = even_par(io.OUTR);
        txd_d      = 1'b0;
        tx_busy_d  = 1'b1;
        tx_cnt_d   = CNT_FULL;
        tx_state_d = TX_START;
      end

      TX_START: begin
        if (tx_tick_s) begin
          txd_d      = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[CHARWIDTH-1:1]};
          tx_bit_d   = BIT_ZERO;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end

      TX_DATA: begin
        if (tx_tick_s) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == BIT_LAST) begin
`ifdef MANO_IO_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = TX_PAR;
`else
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[CHARWIDTH-1:1]};
            tx_bit_d = tx_bit_q + BIT_ONE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end

      TX_PAR: begin
        if (tx_tick_s) begin
          txd_d      = 1'b1;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end

      TX_STOP: begin
        if (tx_tick_s) begin
          tx_state_d = TX_DONE;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end

      // out_start is not looked at here, so a late OUT cannot retrigger.
      TX_DONE: begin
        fgo_set_d  = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end

      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
        tx_busy_d  = 1'b0;
        tx_cnt_d   = CNT_ZERO;
        tx_bit_d   = BIT_ZERO;
      end
    endcase
  end

  // State and output registers for both directions with synchronous reset.
  always_ff @(posedge mclk) begin
    if (mrst) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_prev_q   <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= CNT_ZERO;
      rx_bit_q     <= BIT_ZERO;
      rx_sh_q      <= CHAR_ZERO;
      rx_par_err_q <= 1'b0;
      inpr_data_q  <= CHAR_ZERO;
      inpr_ld_q    <= 1'b0;
      fgi_set_q    <= 1'b0;
      rx_ovr_q     <= 1'b0;
      rx_ferr_q    <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= CNT_ZERO;
      tx_bit_q     <= BIT_ZERO;
      tx_sh_q      <= CHAR_ZERO;
      tx_par_q     <= 1'b0;
      txd_q        <= 1'b1;
      tx_busy_q    <= 1'b0;
      fgo_set_q    <= 1'b0;
    end else begin
      rxd_s1_q     <= rxd_s1_d;
      rxd_s2_q     <= rxd_s2_d;
      rxd_prev_q   <= rxd_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_par_err_q <= rx_par_err_d;
      inpr_data_q  <= inpr_data_d;
      inpr_ld_q    <= inpr_ld_d;
      fgi_set_q    <= fgi_set_d;
      rx_ovr_q     <= rx_ovr_d;
      rx_ferr_q    <= rx_ferr_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      tx_par_q     <= tx_par_d;
      txd_q        <= txd_d;
      tx_busy_q    <= tx_busy_d;
      fgo_set_q    <= fgo_set_d;
    end
  end

  assign io.txd       = txd_q;
  assign io.inpr_data = inpr_data_q;
  assign io.inpr_ld   = inpr_ld_q;
  assign io.fgi_set   = fgi_set_q;
  assign io.fgo_set   = fgo_set_q;
  assign io.tx_busy   = tx_busy_q;
  assign io.rx_ovr    = rx_ovr_q;
  assign io.rx_ferr   = rx_ferr_q;

endmodule

// File: doc/mano_io_term.md
Name: mano_io_term

Overview:
- Terminal-side I/O responder for the MANO computer. It is the device end of the FGI/FGO handshake that the control path drives with INP/OUT instructions.
- Receives serial 8N1 characters on rxd, loads INPR and raises FGI.
- When an OUT instruction clears FGO, it serialises OUTR on txd and raises FGO again at the end of the frame.
- Sits between the datapath flag/register inputs and the external serial pins.

Parameters:
CLKS_PER_BIT, 16, mclk cycles per serial bit; minimum 4; even values only.
CHARWIDTH, 8, INPR/OUTR width and serial data bits per frame.

Ports:
mclk  input  1  system clock
mrst  input  1  reset, synchronous, active-high
rxd  input  1  serial input, idle high, asynchronous to mclk
txd  output  1  serial output, idle high
FGI  input  1  current input-flag level from datapath
FGO  input  1  current output-flag level from datapath
OUTR  input  CHARWIDTH  output register contents
out_start  input  1  one-cycle pulse, same edge as cs_fgo_clr, i.e. OUT executed
inpr_data  output  CHARWIDTH  received character, drives INPR load input
inpr_ld  output  1  one-cycle pulse: load INPR from inpr_data
fgi_set  output  1  one-cycle pulse: set FGI
fgo_set  output  1  one-cycle pulse: set FGO
tx_busy  output  1  high while a frame is being transmitted
rx_ovr  output  1  sticky: character dropped because FGI was still 1
rx_ferr  output  1  sticky: framing error (stop bit 0)
err_clr  input  1  clears rx_ovr and rx_ferr

Behaviour:
- Clock and reset: single clock mclk. mrst is synchronous and active-high; it takes effect at the next mclk edge.
- Reset values: txd=1; inpr_data=0; inpr_ld, fgi_set, fgo_set, tx_busy, rx_ovr, rx_ferr=0; both FSMs in IDLE; bit counters=0.
- Reset mid-frame: the frame is aborted. txd=1 from the reset edge. No flag pulse is produced.
- Input synchronisation: rxd passes through a 2-flop synchroniser before use. All rx timing below is relative to the synchronised signal.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START on a synchronised falling edge (1 then 0).
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If 0 -> DATA; if 1 (glitch) -> IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, CHARWIDTH samples, LSB first, shifted into the rx register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If stop=1 and FGI=0: the next cycle inpr_data<=char, with inpr_ld=1 and fgi_set=1 for exactly one cycle.
    - If stop=1 and FGI=1: char dropped, rx_ovr<=1, inpr_data unchanged.
    - If stop=0: char dropped, rx_ferr<=1.
  - STOP always returns to IDLE. A new start edge is accepted from the cycle after the STOP sample.
- TX FSM, states IDLE, LOAD, START, DATA, STOP, DONE:
  - IDLE: out_start=1 -> LOAD. OUTR is written on the same edge, so it is captured one cycle later.
  - LOAD (1 cycle): shift register <= OUTR, txd<=0, tx_busy<=1 -> START.
  - START: hold txd=0 for CLKS_PER_BIT cycles including the LOAD cycle.
  - DATA: CHARWIDTH bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - DONE (1 cycle): fgo_set=1, tx_busy<=0 -> IDLE.
  - Total: fgo_set is high in the cycle 1+(CHARWIDTH+2)*CLKS_PER_BIT+1 edges after the out_start edge.
- out_start while tx_busy=1 or in DONE: ignored. The current frame is not disturbed and no extra fgo_set is produced.
- Simultaneous events: RX and TX are fully independent. inpr_ld/fgi_set and fgo_set may pulse in the same cycle.
- Error flags: err_clr clears both sticky flags. If err_clr coincides with a new error event, the set wins.
- Counters wrap nowhere: bit and cycle counters are reloaded at every state entry.

Optional Feature:
MANO_IO_PARITY_EN
- Defined:
  - An even-parity bit follows the data bits in both directions; frame = 1 start + CHARWIDTH data + parity + stop, i.e. CHARWIDTH+3 bit times.
  - TX inserts a PARITY state between DATA and STOP.
  - RX checks parity. A mismatch drops the character and sets rx_ferr, even if the stop bit is good.
  - The fgo_set cycle shifts by CLKS_PER_BIT.
- Undefined: no parity state, CHARWIDTH+2 bit frame, behaviour exactly as above.

Test Plan:
1. CLKS_PER_BIT=4, FGI=0: drive rxd frame 0x41 (LSB first, stop=1) -> inpr_data=0x41; inpr_ld and fgi_set high together for one cycle, after the mid-stop sample.
2. OUTR=0xA5, pulse out_start at cycle 10 -> txd pattern 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles, starting cycle 11; fgo_set single pulse at cycle 52; tx_busy low after.
3. FGI held 1, receive 0x55 -> no inpr_ld/fgi_set, rx_ovr=1, inpr_data keeps its prior value; pulse err_clr -> rx_ovr=0.
4. Receive 0x33 with stop bit 0 -> rx_ferr=1, no load. Then a 1-cycle rxd low glitch -> FSM returns to IDLE, no error, no load.
5. Second out_start mid-frame -> txd frame unchanged, exactly one fgo_set. Assert mrst mid-frame -> txd=1, tx_busy=0 at the next edge, no fgo_set.
6. With MANO_IO_PARITY_EN: transmit 0x07 -> parity bit 1 after data, fgo_set at cycle 56 (for the case-2 timing); receive 0x07 with parity 0 -> rx_ferr=1, no load.
